// File: rtl/apb_pkg.sv
// Shared definitions for the APB completers: FSM states, error-cause bit positions, lane widths.
package apb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    localparam int unsigned APB_ERR_RANGE = 0;
    localparam int unsigned APB_ERR_ALIGN = 1;
    localparam int unsigned APB_ERR_RO    = 2;
    localparam int unsigned APB_ERR_PRIV  = 3;
    localparam int unsigned APB_ERR_W     = 4;

    localparam int unsigned APB_STRB_W = 4;
    localparam int unsigned APB_IDX_W  = 6;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with byte-strobe write port, read mux and read-only status slot.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  we,
    input  logic [APB_IDX_W-1:0]  wr_idx,
    input  logic [31:0]           wdata,
    input  logic [APB_STRB_W-1:0] wstrb,
    input  logic [APB_IDX_W-1:0]  rd_idx,
    output logic [31:0]           rdata,
    input  logic [31:0]           status_in,
    output logic [31:0]           ctrl_out
);

    logic [31:0] regs [NUM_REGS-1];

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (wr_idx == APB_IDX_W'(i)) begin
                    for (int unsigned k = 0; k < APB_STRB_W; k++) begin
                        if (wstrb[k]) begin
                            regs[i][8*k +: 8] <= wdata[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Status slot bypasses storage: prdata captures status_in on the very edge it loads.
    always_comb begin
        rdata = '0;
        if (rd_idx == APB_IDX_W'(NUM_REGS - 1)) begin
            rdata = status_in;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
                if (rd_idx == APB_IDX_W'(i)) begin
                    rdata = regs[i];
                end
            end
        end
    end

    assign ctrl_out = regs[0];

endmodule

// File: rtl/apb_reg_completer.sv
// APB4 completer for a control/status register bank: wait states, strobes, privilege and error response.
module apb_reg_completer
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [15:0] PRIV_MASK   = 16'h0001
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic [31:0]           paddr,
    input  logic                  pwrite,
    input  logic [2:0]            pprot,
    input  logic [31:0]           pwdata,
    input  logic [APB_STRB_W-1:0] pstrb,
    output logic [31:0]           prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [31:0]           status_in,
    output logic [31:0]           ctrl_out
);

    localparam logic [63:0] PRIV_VEC = 64'(PRIV_MASK);
    localparam logic [31:0] SPAN     = 32'(4 * NUM_REGS);

    apb_state_e            st;
    logic [3:0]            cnt;
    logic [APB_IDX_W-1:0]  idx, lat_idx, rd_idx;
    logic                  lat_write, lat_err;
    logic [31:0]           lat_wdata;
    logic [APB_STRB_W-1:0] lat_strb;
    logic [31:0]           offset, bank_rdata, rd_val;
    logic [APB_ERR_W-1:0]  cause;
    logic                  setup_err, commit;
    logic [1:0]            unused_prot;

    assign unused_prot = pprot[2:1];

    always_comb begin
        offset = paddr - BASE_ADDR;
        idx    = offset[APB_IDX_W+1:2];
        cause  = '0;
        cause[APB_ERR_RANGE] = offset >= SPAN;
        cause[APB_ERR_ALIGN] = offset[1:0] != 2'b00;
        cause[APB_ERR_RO]    = pwrite && (idx == APB_IDX_W'(NUM_REGS - 1));
        cause[APB_ERR_PRIV]  = pwrite && !pprot[0] && PRIV_VEC[idx];
        setup_err = |cause;
    end

    // Before the setup edge the bus fields are still live; afterwards use the latched copies.
    always_comb begin
        rd_idx = (st == IDLE) ? idx : lat_idx;
        rd_val = bank_rdata;
        if (st == IDLE) begin
            if (setup_err || pwrite) rd_val = '0;
        end else begin
            if (lat_err || lat_write) rd_val = '0;
        end
    end

    assign pready  = (st == ACCESS) && (cnt == '0);
    assign pslverr = pready && lat_err;
    assign commit  = pready && psel && penable && lat_write && !lat_err;

    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            st        <= IDLE;
            cnt       <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
            lat_err   <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            prdata    <= '0;
        end else begin
            case (st)
                IDLE: begin
                    prdata <= '0;
                    if (psel && !penable) begin
                        lat_idx   <= idx;
                        lat_write <= pwrite;
                        lat_err   <= setup_err;
                        lat_wdata <= pwdata;
                        lat_strb  <= pstrb;
                        cnt       <= 4'(WAIT_STATES);
                        st        <= ACCESS;
                        if (WAIT_STATES == 0) prdata <= rd_val;
                    end
                end
                ACCESS: begin
                    if (!psel) begin
                        st     <= IDLE;
                        cnt    <= '0;
                        prdata <= '0;
                    end else if (penable) begin
                        if (cnt == '0) begin
                            st     <= IDLE;
                            prdata <= '0;
                        end else begin
                            cnt <= cnt - 4'd1;
                            if (cnt == 4'd1) prdata <= rd_val;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    apb_reg_bank #(
        .NUM_REGS (NUM_REGS)
    ) u_bank (
        .pclk      (pclk),
        .preset    (preset),
        .we        (commit),
        .wr_idx    (lat_idx),
        .wdata     (lat_wdata),
        .wstrb     (lat_strb),
        .rd_idx    (rd_idx),
        .rdata     (bank_rdata),
        .status_in (status_in),
        .ctrl_out  (ctrl_out)
    );

endmodule

// File: tb/tb_apb_reg_completer.sv
// Directed bench for apb_reg_completer: one instance with 1 wait state, one with 3, sharing the bus.
module tb_apb_reg_completer;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr, pwdata, status_in;
    logic [3:0]  pstrb;
    logic [31:0] prdata0, prdata1, ctrl0, ctrl1;
    logic        pready0, pready1, pslverr0, pslverr1;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 pclk = ~pclk;

    apb_reg_completer #(
        .BASE_ADDR   (32'h0000_0000),
        .NUM_REGS    (16),
        .WAIT_STATES (1),
        .PRIV_MASK   (16'h0001)
    ) dut0 (
        .pclk (pclk), .preset (preset), .psel (psel[0]), .penable (penable),
        .paddr (paddr), .pwrite (pwrite), .pprot (pprot), .pwdata (pwdata),
        .pstrb (pstrb), .prdata (prdata0), .pready (pready0), .pslverr (pslverr0),
        .status_in (status_in), .ctrl_out (ctrl0)
    );

    apb_reg_completer #(
        .BASE_ADDR   (32'h0000_0000),
        .NUM_REGS    (16),
        .WAIT_STATES (3),
        .PRIV_MASK   (16'h0001)
    ) dut1 (
        .pclk (pclk), .preset (preset), .psel (psel[1]), .penable (penable),
        .paddr (paddr), .pwrite (pwrite), .pprot (pprot), .pwdata (pwdata),
        .pstrb (pstrb), .prdata (prdata1), .pready (pready1), .pslverr (pslverr1),
        .status_in (status_in), .ctrl_out (ctrl1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered just after a rising edge; returns just after the completion edge with the bus idle.
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input logic exp_err, input logic [31:0] exp_rd, input string tag);
        exp_t        e;
        int          n;
        logic        rdy, se;
        logic [31:0] rd;
        sb.push_back('{rdata: exp_rd, err: exp_err});
        psel    = (d == 1) ? 2'b10 : 2'b01;
        penable = 1'b0;
        paddr   = addr;
        pwrite  = wr;
        pwdata  = data;
        pstrb   = strb;
        pprot   = prot;
        @(posedge pclk); #1;
        penable = 1'b1;
        n   = 0;
        rdy = 1'b0;
        while (!rdy && n < 20) begin
            @(negedge pclk);
            n++;
            rdy = (d == 1) ? pready1 : pready0;
        end
        chk({tag, ".latency"}, 32'(n), (d == 1) ? 32'd4 : 32'd2);
        e  = sb.pop_front();
        se = (d == 1) ? pslverr1 : pslverr0;
        rd = (d == 1) ? prdata1 : prdata0;
        chk({tag, ".pslverr"}, {31'b0, se}, {31'b0, e.err});
        chk({tag, ".prdata"}, rd, e.rdata);
        @(posedge pclk); #1;
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        preset    = 1'b0;
        psel      = 2'b00;
        penable   = 1'b0;
        pwrite    = 1'b0;
        pprot     = 3'b000;
        paddr     = '0;
        pwdata    = '0;
        pstrb     = '0;
        status_in = '0;

        @(negedge pclk);
        chk("rst.prdata",  prdata0, 32'h0);
        chk("rst.pready",  {31'b0, pready0}, 32'h0);
        chk("rst.pslverr", {31'b0, pslverr0}, 32'h0);
        chk("rst.ctrl",    ctrl0, 32'h0);
        chk("rst.ctrl1",   ctrl1, 32'h0);
        preset = 1'b1;
        @(posedge pclk); #1;

        xfer(0, 1'b1, 32'h04, 32'hDEAD_BEEF, 4'hF, 3'b000, 1'b0, 32'h0, "wr_r1");
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'hDEAD_BEEF, "rd_r1");

        xfer(0, 1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF, 3'b000, 1'b0, 32'h0, "wr_r2_ones");
        xfer(0, 1'b1, 32'h08, 32'h1122_3344, 4'b0101, 3'b000, 1'b0, 32'h0, "wr_r2_strb");
        xfer(0, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000, 1'b0, 32'hFF22_FF44, "rd_r2");

        xfer(0, 1'b1, 32'h00, 32'h5, 4'hF, 3'b000, 1'b1, 32'h0, "wr_r0_unpriv");
        @(negedge pclk);
        chk("ctrl_after_unpriv", ctrl0, 32'h0);
        @(posedge pclk); #1;
        xfer(0, 1'b1, 32'h00, 32'h5, 4'hF, 3'b001, 1'b0, 32'h0, "wr_r0_priv");
        @(negedge pclk);
        chk("ctrl_after_priv", ctrl0, 32'h5);
        @(posedge pclk); #1;

        status_in = 32'hCAFE_0001;
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 1'b0, 32'hCAFE_0001, "rd_status");
        xfer(0, 1'b1, 32'h3C, 32'h1234_5678, 4'hF, 3'b001, 1'b1, 32'h0, "wr_status");
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 1'b0, 32'hCAFE_0001, "rd_status2");
        status_in = 32'h0000_1234;
        xfer(0, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0000_1234, "rd_status3");

        xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0, "rd_range");
        xfer(0, 1'b0, 32'h02, 32'h0, 4'h0, 3'b000, 1'b1, 32'h0, "rd_align");
        xfer(0, 1'b1, 32'h0A, 32'h0, 4'hF, 3'b001, 1'b1, 32'h0, "wr_align");
        xfer(0, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 1'b0, 32'hFF22_FF44, "rd_r2_after_err");

        xfer(0, 1'b1, 32'h04, 32'h0000_0000, 4'h0, 3'b000, 1'b0, 32'h0, "wr_r1_nostrb");
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'hDEAD_BEEF, "rd_r1_nostrb");

        // Access phase without a preceding setup must not start a transfer.
        psel    = 2'b01;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 32'h04;
        @(posedge pclk);
        @(negedge pclk);
        chk("idle_penable.pready", {31'b0, pready0}, 32'h0);
        chk("idle_penable.state",  {31'b0, dut0.st}, {31'b0, IDLE});
        @(posedge pclk); #1;
        psel    = 2'b00;
        penable = 1'b0;

        xfer(1, 1'b1, 32'h04, 32'h0000_ABCD, 4'hF, 3'b001, 1'b0, 32'h0, "ws3_wr_r1");
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0000_ABCD, "ws3_rd_r1");

        psel    = 2'b10;
        penable = 1'b0;
        paddr   = 32'h04;
        pwrite  = 1'b1;
        pwdata  = 32'h9999_9999;
        pstrb   = 4'hF;
        pprot   = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel    = 2'b00;
        penable = 1'b0;
        @(posedge pclk);
        @(negedge pclk);
        chk("abort.state",  {31'b0, dut1.st}, {31'b0, IDLE});
        chk("abort.pready", {31'b0, pready1}, 32'h0);
        @(posedge pclk); #1;
        xfer(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0000_ABCD, "ws3_rd_after_abort");

        psel    = 2'b01;
        penable = 1'b0;
        paddr   = 32'h04;
        pwrite  = 1'b1;
        pwdata  = 32'h7777_7777;
        pstrb   = 4'hF;
        pprot   = 3'b001;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        chk("midrst.pready_before", {31'b0, pready0}, 32'h1);
        #2;
        preset = 1'b0;
        #1;
        chk("midrst.pready",  {31'b0, pready0}, 32'h0);
        chk("midrst.pslverr", {31'b0, pslverr0}, 32'h0);
        chk("midrst.prdata",  prdata0, 32'h0);
        chk("midrst.ctrl",    ctrl0, 32'h0);
        psel    = 2'b00;
        penable = 1'b0;
        @(negedge pclk);
        preset = 1'b1;
        @(posedge pclk); #1;
        xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 1'b0, 32'h0, "rd_r1_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
